// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and types for the memory port arbiter.
package mem_arb_pkg;
    localparam int NREQ_D = 4;
    localparam int AW_D = 6;
    localparam int DW_D = 8;
    localparam int IDW = $clog2(NREQ_D);
    typedef struct packed {
        logic wr;
        logic [AW_D-1:0] addr;
        logic [DW_D-1:0] wdata;
    } mem_cmd_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set bit at or after ptr wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int IW = $clog2(NREQ_D)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        // Scan from farthest to nearest so the closest set bit to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
        any = |req;
        gnt = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous single-port memory among NREQ requesters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int AW = AW_D,
    parameter int DW = DW_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     rvalid,
    output logic [$clog2(NREQ)-1:0]  rid,
    output logic [DW-1:0]            rdata
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] ptr, idx, rd_id;
    logic [NREQ-1:0] pick;
    logic any, rd_pend;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(ptr),
        .gnt(pick),
        .idx(idx),
        .any(any)
    );

    assign gnt = rst ? '0 : pick;
    assign rdata = mem_rdata;

    // rd_pend tracks the command stage; rvalid/rid are one stage later to meet the memory's read data.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rd_pend <= 1'b0;
            rd_id <= '0;
            rvalid <= 1'b0;
            rid <= '0;
        end else begin
            mem_en <= any;
            rd_pend <= any && !req_wr[idx];
            rvalid <= rd_pend;
            rid <= rd_id;
            if (any) begin
                ptr <= IW'((int'(idx) + 1) % NREQ);
                mem_wr <= req_wr[idx];
                mem_addr <= req_addr[int'(idx)*AW +: AW];
                mem_wdata <= req_wdata[int'(idx)*DW +: DW];
                rd_id <= idx;
            end
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and sequence checks of the round-robin memory port arbiter with a scoreboard.
module tb_mem_port_arbiter;
    localparam int N = 4, AW = 6, DW = 8;
    logic clk = 0, rst = 0;
    logic [N-1:0] req = '0, req_wr = '0, gnt;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic mem_en, mem_wr, rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;
    logic [1:0] rid;
    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] mem [64];
    logic [7:0] shadow [64];

    typedef struct {logic [3:0] req, wr; logic [23:0] addr; logic [31:0] wdata; logic [3:0] gnt;} vec_t;
    typedef struct {int due; logic en, wr; logic [5:0] addr; logic [7:0] wdata;} cmd_e;
    typedef struct {int due; logic rv; logic [1:0] id; logic [7:0] data;} rd_e;
    cmd_e cq[$];
    rd_e rq[$];
    cmd_e ce;
    rd_e re;
    vec_t tbl [21];

    mem_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rvalid(rvalid), .rid(rid), .rdata(rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 64; i++) begin
        mem[i] = 8'(i) ^ 8'h03;
        shadow[i] = 8'(i) ^ 8'h03;
    end
    initial mem_rdata = '0;
    always @(posedge clk)
        if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_wr"}, 32'(mem_wr), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " rvalid"}, 32'(rvalid), 0);
        chk({tag, " rid"}, 32'(rid), 0);
    endtask

    always @(negedge clk) begin
        while (cq.size() > 0 && cq[0].due == cyc) begin
            ce = cq.pop_front();
            chk("mem_en", 32'(mem_en), 32'(ce.en));
            if (ce.en) begin
                chk("mem_wr", 32'(mem_wr), 32'(ce.wr));
                chk("mem_addr", 32'(mem_addr), 32'(ce.addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(ce.wdata));
            end
        end
        while (rq.size() > 0 && rq[0].due == cyc) begin
            re = rq.pop_front();
            chk("rvalid", 32'(rvalid), 32'(re.rv));
            if (re.rv) begin
                chk("rid", 32'(rid), 32'(re.id));
                chk("rdata", 32'(rdata), 32'(re.data));
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [23:0] a,
                        input logic [31:0] d, input logic [3:0] g);
        int wi;
        logic en;
        logic [5:0] ad;
        @(posedge clk);
        #1;
        req = r; req_wr = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(g));
        wi = 0;
        for (int k = 0; k < N; k++) if (g[k]) wi = k;
        en = (g != 0);
        ad = a[wi*6 +: 6];
        cq.push_back('{cyc + 1, en, w[wi], ad, d[wi*8 +: 8]});
        rq.push_back('{cyc + 2, en && !w[wi], 2'(wi), shadow[ad]});
        if (en && w[wi]) shadow[ad] = d[wi*8 +: 8];
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 4'b0001, {18'd0, 6'd5}, {24'd0, 8'hA5}, 4'b0001};
        tbl[1]  = '{4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b0000, {6'd0, 6'd63, 12'd0}, 32'd0, 4'b0100};
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = '{4'b0010, 4'b0010, {12'd0, 6'd63, 6'd0}, {16'd0, 8'h77, 8'd0}, 4'b0010};
        tbl[6]  = '{4'b1010, 4'b0010, {6'd63, 6'd0, 6'd10, 6'd0}, {16'd0, 8'h11, 8'd0}, 4'b1000};
        tbl[7]  = '{4'b1010, 4'b0010, {6'd63, 6'd0, 6'd10, 6'd0}, {16'd0, 8'h11, 8'd0}, 4'b0010};
        for (int i = 8; i < 13; i++) tbl[i] = tbl[1];
        tbl[13] = '{4'b1111, 4'b0101, {6'd40, 6'd30, 6'd20, 6'd10}, {8'hD3, 8'hD2, 8'hD1, 8'hD0}, 4'b0100};
        tbl[14] = tbl[13]; tbl[14].gnt = 4'b1000;
        tbl[15] = tbl[13]; tbl[15].gnt = 4'b0001;
        tbl[16] = tbl[13]; tbl[16].gnt = 4'b0010;
        tbl[17] = tbl[13]; tbl[17].gnt = 4'b0100;
        tbl[18] = '{4'b0001, 4'b0000, {18'd0, 6'd10}, 32'd0, 4'b0001};
        tbl[19] = tbl[1];
        tbl[20] = tbl[1];

        #1 rst = 1;
        #2 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 0;

        for (int i = 0; i < 21; i++)
            step(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].gnt);

        // Reset while a read is between command and data return.
        step(4'b0100, 4'b0000, {6'd0, 6'd63, 12'd0}, 32'd0, 4'b0100);
        step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000);
        #1;
        cq.delete();
        rq.delete();
        #1 rst = 1;
        #1 chk_zero("midrst");
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b0000);
        chk_zero("inrst1");
        step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000);
        chk_zero("inrst2");
        rst = 0;
        step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000);
        step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000);
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b0001);
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b0010);
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b0100);
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b1000);
        step(4'b1111, 4'b0000, {6'd40, 6'd30, 6'd20, 6'd10}, 32'd0, 4'b0001);
        repeat (3) step(4'b0000, 4'b0000, 24'd0, 32'd0, 4'b0000);
        repeat (2) @(negedge clk);
        #1 chk("drained", 32'(cq.size() + rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port synchronous memory (6-bit address, write strobe, enable) among NREQ requesters. It sits between the requester blocks and the memory instance. Each cycle it picks one pending request, registers it onto the memory command port and routes read data back to the originating requester. It sustains one access per cycle, back to back.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 6, memory address width
- DW, 8, memory data width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request; payload must be stable while req is high
- req_wr  in  NREQ  per-requester access type: 1 = write, 0 = read
- req_addr  in  NREQ*AW  per-requester address; requester i in bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  per-requester write data, packed the same way
- gnt  out  NREQ  one-hot, combinational; the request is accepted in the cycle gnt[i] is high
- mem_en  out  1  registered memory enable
- mem_wr  out  1  registered write strobe
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  read data, valid the cycle after mem_en=1 with mem_wr=0
- rvalid  out  1  read data valid
- rid  out  $clog2(NREQ)  index of the requester that owns rdata
- rdata  out  DW  read data, equal to mem_rdata

## Operation
- Clock is clk. Reset is rst, asynchronous and active-high.
- State consists of:
  - rr pointer ptr (index of the highest-priority requester)
  - registered command (mem_en, mem_wr, mem_addr, mem_wdata)
  - read-tag pipeline: rd_pend plus rd_id, one stage
- Arbitration runs every cycle with no idle states.
  - Search req starting at ptr, ascending with wrap-around modulo NREQ.
  - The first set bit wins. gnt gets that bit one-hot.
  - If req is all zeros, gnt = 0.
- On the edge that ends a grant cycle:
  - mem_en=1. mem_wr, mem_addr and mem_wdata take the winner's payload.
  - ptr = (winner+1) mod NREQ.
  - rd_pend = !req_wr[winner], rd_id = winner.
- With no grant, mem_en=0, rd_pend=0 and ptr is unchanged. mem_addr, mem_wr and mem_wdata hold their last values (don't-care).
- Read return:
  - rvalid = rd_pend, delayed so it aligns with mem_rdata.
  - rid = rd_id. rdata = mem_rdata, combinational passthrough.
  - Writes never produce rvalid.
- A requester may drop or change req and payload in the cycle after its gnt. If it keeps req high, it re-enters arbitration and now has the lowest priority.
- While rst is high, gnt is forced to 0.

## Timing
- Reset values:
  - ptr=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0
  - rd_pend=0, rvalid=0, rid=0, gnt=0
- The request is sampled and gnt is issued in cycle t.
- The memory command is visible in cycle t+1.
- For reads, mem_rdata, rvalid, rid and rdata are all valid in cycle t+2. Read latency from grant is 2 cycles.
- Throughput is 1 grant per cycle. With k requesters continuously active, each is granted once every k cycles.
- Simultaneous requests: the winner is the first set bit at or after ptr. Requesters never starve; maximum wait is NREQ-1 grants.
- ptr wraps from NREQ-1 to 0.
- Read followed immediately by write: the write command in t+2 overlaps the read data return in t+2. This is legal because the memory is synchronous.
- Reset mid-operation: in-flight reads are discarded and rvalid stays 0 until a new read is granted after rst deasserts. ptr returns to 0.

## Structure
- Package mem_arb_pkg holds:
  - default AW, DW and NREQ constants
  - typedef mem_cmd_t: struct packed {wr, addr[AW], wdata[DW]}
  - localparam IDW = $clog2(NREQ)
- Sub-module rr_pick: purely combinational rotating priority picker.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: gnt one-hot, idx, any.
  - Instantiated once. Registers live in mem_port_arbiter.

## Test plan
- Lone write: req=0001, wr=1, addr=5, wdata=0xA5 at t.
  - Cycle t: gnt=0001.
  - Cycle t+1: mem_en=1, mem_wr=1, mem_addr=5, mem_wdata=0xA5.
  - rvalid stays 0 throughout.
- All requesters held at req=1111 from reset: gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with mem_en=1 every cycle from t+1.
- Read: req2 reads addr 63 at t; the memory model drives mem_rdata=0x3C in t+2.
  - Cycle t+2: rvalid=1, rid=2, rdata=0x3C.
  - Cycle t+3: rvalid=0.
- Rotation after a req1 grant (ptr=2), then req=1010: gnt=1000 first, then 0010 on the next cycle.
- rst asserted in cycle t+1 of a pending read:
  - All outputs go to 0 immediately.
  - No rvalid after release.
  - The next req=1111 grants requester 0 first.
- req=0000 for 5 cycles: gnt=0 and mem_en=0 throughout. ptr is unchanged, verified by the next grant order.
